// File: rtl/axi_print_eoc_monitor.sv
// Passive AXI write-channel monitor: tags each accepted AW, pairs W beats with their AW,
// and turns STDOUT/STDERR/EOC register writes into character, error-code and exit-code outputs.
module axi_print_eoc_monitor #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] STDERR_ADDR = 32'h2FFF_0000,
    parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'h2FFF_0004,
    parameter logic [ADDR_W-1:0] EOC_ADDR    = 32'h2C03_0000,
    parameter int                MAX_OUTST   = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           aw_valid_i,
    input  logic                           aw_ready_i,
    input  logic [ADDR_W-1:0]              aw_addr_i,
    input  logic                           w_valid_i,
    input  logic                           w_ready_i,
    input  logic [DATA_W-1:0]              w_data_i,
    input  logic [DATA_W/8-1:0]            w_strb_i,
    input  logic                           w_last_i,
    output logic                           char_valid_o,
    output logic [7:0]                     char_o,
    output logic                           err_valid_o,
    output logic [31:0]                    err_code_o,
    output logic                           eoc_o,
    output logic [31:0]                    exit_code_o,
    output logic [$clog2(MAX_OUTST):0]     outst_o,
    output logic                           proto_err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(MAX_OUTST);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << LANE_W) - 1);

    typedef enum logic [1:0] {
        TAG_OTHER  = 2'd0,
        TAG_STDOUT = 2'd1,
        TAG_STDERR = 2'd2,
        TAG_EOC    = 2'd3
    } tag_e;

    function automatic tag_e classify(input logic [ADDR_W-1:0] word_addr);
        tag_e t;
        if (word_addr == STDOUT_ADDR) begin
            t = TAG_STDOUT;
        end else if (word_addr == STDERR_ADDR) begin
            t = TAG_STDERR;
        end else if (word_addr == EOC_ADDR) begin
            t = TAG_EOC;
        end else begin
            t = TAG_OTHER;
        end
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] mask_word(input logic [DATA_W-1:0] d,
                                                    input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < STRB_W; i++) begin
            m[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'h00;
        end
        return m;
    endfunction

    // The character is the byte in the lowest lane whose strobe is set.
    function automatic logic [7:0] low_lane_byte(input logic [DATA_W-1:0] d,
                                                 input logic [STRB_W-1:0] s);
        logic [7:0] b;
        logic       found;
        b     = 8'h00;
        found = 1'b0;
        for (int i = 0; i < STRB_W; i++) begin
            if (s[i] && !found) begin
                b     = d[8*i +: 8];
                found = 1'b1;
            end
        end
        return b;
    endfunction

    tag_e               tag_mem_r [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               char_valid_r;
    logic [7:0]         char_r;
    logic               err_valid_r;
    logic [31:0]        err_code_r;
    logic               eoc_r;
    logic [31:0]        exit_code_r;
    logic               proto_err_r;

    logic               awhs_s;
    logic               whs_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    tag_e               new_tag_s;
    tag_e               beat_tag_s;
    logic               beat_ok_s;
    logic               bypass_s;
    logic               orphan_s;
    logic               pop_s;
    logic               push_s;
    logic               overflow_s;
    logic [DATA_W-1:0]  masked_s;
    logic [31:0]        word_s;
    logic [7:0]         char_s;
    logic               char_en_s;
    logic               err_en_s;
    logic               eoc_en_s;

    // Handshake decode, tag selection and FIFO push/pop decisions.
    always_comb begin
        awhs_s       = aw_valid_i & aw_ready_i;
        whs_s        = w_valid_i & w_ready_i;
        fifo_empty_s = (cnt_r == {CNT_W{1'b0}});
        fifo_full_s  = (cnt_r == CNT_W'(MAX_OUTST));
        new_tag_s    = classify(aw_addr_i & ~LOW_MASK);
        bypass_s     = whs_s & fifo_empty_s & awhs_s;
        orphan_s     = whs_s & fifo_empty_s & ~awhs_s;
        beat_ok_s    = whs_s & (~fifo_empty_s | awhs_s);
        if (fifo_empty_s) begin
            beat_tag_s = new_tag_s;
        end else begin
            beat_tag_s = tag_mem_r[rd_ptr_r];
        end
        pop_s = whs_s & w_last_i & ~fifo_empty_s;
        // A bypassed first beat of a longer burst still needs its tag queued for later beats.
        push_s     = awhs_s & ~(bypass_s & w_last_i) & (~fifo_full_s | pop_s);
        overflow_s = awhs_s & fifo_full_s & ~pop_s;
    end

    // Beat payload decode and per-class effect enables.
    always_comb begin
        masked_s  = mask_word(w_data_i, w_strb_i);
        word_s    = masked_s[31:0];
        char_s    = low_lane_byte(w_data_i, w_strb_i);
        char_en_s = 1'b0;
        err_en_s  = 1'b0;
        eoc_en_s  = 1'b0;
        if (beat_ok_s) begin
            case (beat_tag_s)
                TAG_STDOUT: char_en_s = (w_strb_i != {STRB_W{1'b0}}) && (char_s != 8'h00);
                TAG_STDERR: err_en_s  = (word_s != 32'h0);
                TAG_EOC:    eoc_en_s  = (word_s != 32'h0) && !eoc_r;
                TAG_OTHER:  char_en_s = 1'b0;
                default:    char_en_s = 1'b0;
            endcase
        end else begin
            char_en_s = 1'b0;
        end
    end

    // Outstanding-AW tag FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < MAX_OUTST; i++) begin
                tag_mem_r[i] <= TAG_OTHER;
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= new_tag_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            cnt_r <= cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Registered print, error, exit-code and protocol-error outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            char_valid_r <= 1'b0;
            char_r       <= 8'h00;
            err_valid_r  <= 1'b0;
            err_code_r   <= 32'h0;
            eoc_r        <= 1'b0;
            exit_code_r  <= 32'h0;
            proto_err_r  <= 1'b0;
        end else begin
            char_valid_r <= char_en_s;
            if (char_en_s) begin
                char_r <= char_s;
            end
            if (err_en_s) begin
                err_code_r  <= word_s;
                err_valid_r <= 1'b1;
            end
            if (eoc_en_s) begin
                exit_code_r <= word_s;
                eoc_r       <= 1'b1;
            end
            if (orphan_s || overflow_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign char_valid_o = char_valid_r;
    assign char_o       = char_r;
    assign err_valid_o  = err_valid_r;
    assign err_code_o   = err_code_r;
    assign eoc_o        = eoc_r;
    assign exit_code_o  = exit_code_r;
    assign outst_o      = cnt_r;
    assign proto_err_o  = proto_err_r;

endmodule

// File: tb/tb_axi_print_eoc_monitor.sv
// Randomized + directed bench for axi_print_eoc_monitor; a queue-based transaction model
// predicts every output each cycle, and literal checks pin the directed scenarios.
module tb_axi_print_eoc_monitor;

    localparam logic [31:0] STDERR_A = 32'h2FFF_0000;
    localparam logic [31:0] STDOUT_A = 32'h2FFF_0004;
    localparam logic [31:0] EOC_A    = 32'h2C03_0000;
    localparam int          MAXO     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_valid = 1'b0, aw_ready = 1'b0;
    logic [31:0] aw_addr = 32'h0;
    logic        w_valid = 1'b0, w_ready = 1'b0;
    logic [31:0] w_data = 32'h0;
    logic [3:0]  w_strb = 4'h0;
    logic        w_last = 1'b0;
    logic        char_valid, err_valid, eoc, proto_err;
    logic [7:0]  char_v;
    logic [31:0] err_code, exit_code;
    logic [3:0]  outst;

    int checks = 0;
    int failures = 0;
    int printed = 0;
    bit armed = 1'b0;

    axi_print_eoc_monitor dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_i(w_ready), .w_data_i(w_data),
        .w_strb_i(w_strb), .w_last_i(w_last),
        .char_valid_o(char_valid), .char_o(char_v),
        .err_valid_o(err_valid), .err_code_o(err_code),
        .eoc_o(eoc), .exit_code_o(exit_code),
        .outst_o(outst), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          q[$];
    bit          m_char_valid, m_err_valid, m_eoc, m_proto;
    logic [7:0]  m_char;
    logic [31:0] m_err_code, m_exit_code;
    int          m_outst;
    bit          s_awhs, s_whs, s_bypass, s_pop;
    int          s_tag, s_new;
    logic [31:0] s_word;
    logic [7:0]  s_c;

    function automatic int classify(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == STDOUT_A) return 1;
        if (w == STDERR_A) return 2;
        if (w == EOC_A) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
        return m;
    endfunction

    function automatic logic [7:0] first_byte(input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return d[8*i +: 8];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_char_valid = 0; m_char = 8'h00; m_err_valid = 0; m_err_code = 32'h0;
            m_eoc = 0; m_exit_code = 32'h0; m_proto = 0; m_outst = 0;
        end else begin
            s_awhs = aw_valid & aw_ready;
            s_whs  = w_valid & w_ready;
            s_new  = classify(aw_addr);
            s_tag = -1; s_bypass = 0; s_pop = 0;
            m_char_valid = 0;
            if (s_whs) begin
                if (q.size() > 0) begin
                    s_tag = q[0];
                    s_pop = w_last;
                end else if (s_awhs) begin
                    s_tag = s_new;
                    s_bypass = 1;
                end else begin
                    m_proto = 1;
                end
            end
            s_word = masked(w_data, w_strb);
            s_c    = first_byte(w_data, w_strb);
            if (s_tag == 1 && s_c != 8'h00) begin
                m_char_valid = 1; m_char = s_c;
            end
            if (s_tag == 2 && s_word != 32'h0) begin
                m_err_valid = 1; m_err_code = s_word;
            end
            if (s_tag == 3 && s_word != 32'h0 && !m_eoc) begin
                m_eoc = 1; m_exit_code = s_word;
            end
            if (s_pop) void'(q.pop_front());
            if (s_awhs && !(s_bypass && w_last)) begin
                if (q.size() < MAXO) q.push_back(s_new);
                else m_proto = 1;
            end
            m_outst = q.size();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (char_valid !== m_char_valid || (m_char_valid && char_v !== m_char) ||
                err_valid !== m_err_valid || err_code !== m_err_code ||
                eoc !== m_eoc || exit_code !== m_exit_code ||
                outst !== 4'(m_outst) || proto_err !== m_proto) begin
                failures++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL model t=%0t got cv=%0b c=%h ev=%0b e=%h eoc=%0b x=%h o=%0d p=%0b exp cv=%0b c=%h ev=%0b e=%h eoc=%0b x=%h o=%0d p=%0b",
                             $time, char_valid, char_v, err_valid, err_code, eoc, exit_code, outst, proto_err,
                             m_char_valid, m_char, m_err_valid, m_err_code, m_eoc, m_exit_code, m_outst, m_proto);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle();
        aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; w_last = 0;
    endtask

    task automatic do_aw(input logic [31:0] a);
        aw_valid = 1; aw_ready = 1; aw_addr = a;
        tick();
        idle();
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        w_valid = 1; w_ready = 1; w_data = d; w_strb = s; w_last = l;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        armed = 1;
        chk("reset_outst", 32'(outst), 32'd0);
        chk("reset_flags", {28'h0, char_valid, err_valid, eoc, proto_err}, 32'h0);

        // single STDOUT write
        do_aw(STDOUT_A);
        chk("outst_after_aw", 32'(outst), 32'd1);
        do_w(32'h0000_0048, 4'b0001, 1'b1);
        chk("char_valid_48", 32'(char_valid), 32'd1);
        chk("char_48", 32'(char_v), 32'h48);
        chk("outst_back_0", 32'(outst), 32'd0);
        tick();
        chk("char_pulse_ends", 32'(char_valid), 32'd0);

        // non-print write, then three outstanding AWs
        do_aw(32'h1000_0000);
        do_w(32'h41, 4'b0001, 1'b1);
        chk("other_no_char", 32'(char_valid), 32'd0);
        do_aw(32'h1000_0000); do_aw(STDOUT_A); do_aw(STDERR_A);
        chk("outst_3", 32'(outst), 32'd3);
        do_w(32'h11, 4'b0001, 1'b1);
        chk("no_char_11", 32'(char_valid), 32'd0);
        do_w(32'h2A, 4'b0001, 1'b1);
        chk("char_2a", {23'h0, char_valid, char_v}, {23'h0, 1'b1, 8'h2A});
        do_w(32'h05, 4'b1111, 1'b1);
        chk("err_code_5", err_code, 32'd5);
        chk("err_valid", 32'(err_valid), 32'd1);

        // same-cycle AW+W bypass
        aw_valid = 1; aw_ready = 1; aw_addr = STDOUT_A;
        w_valid = 1; w_ready = 1; w_data = 32'h0000_4300; w_strb = 4'b0010; w_last = 1;
        tick(); idle();
        chk("bypass_char", {23'h0, char_valid, char_v}, {23'h0, 1'b1, 8'h43});
        chk("bypass_outst", 32'(outst), 32'd0);
        chk("bypass_no_proto", 32'(proto_err), 32'd0);

        // EOC sequence
        do_aw(EOC_A); do_w(32'h0, 4'hF, 1'b1);
        chk("eoc_zero_ignored", 32'(eoc), 32'd0);
        do_aw(EOC_A); do_w(32'h1, 4'hF, 1'b1);
        chk("eoc_rise", {eoc, exit_code[30:0]}, {1'b1, 31'd1});
        do_aw(EOC_A); do_w(32'h7, 4'hF, 1'b1);
        chk("exit_frozen", exit_code, 32'd1);

        // overflow
        do_reset();
        for (int i = 0; i < 8; i++) do_aw(STDOUT_A);
        chk("full_8_no_proto", {31'(outst), proto_err}, {31'd8, 1'b0});
        do_aw(STDOUT_A);
        chk("overflow_proto", {31'(outst), proto_err}, {31'd8, 1'b1});

        // W without AW
        do_reset();
        do_w(32'h55, 4'b0001, 1'b1);
        chk("orphan_proto", 32'(proto_err), 32'd1);

        // reset with two tags outstanding
        do_reset();
        do_aw(STDOUT_A); do_aw(STDERR_A);
        chk("outst_2", 32'(outst), 32'd2);
        do_reset();
        chk("rst_clears", {27'h0, outst, proto_err}, 32'h0);
        do_w(32'h33, 4'b0001, 1'b1);
        chk("post_reset_beat_proto", {30'h0, proto_err, char_valid}, 32'h2);

        // randomized phase
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 399) == 0);
            aw_valid = ($urandom_range(0, 9) < 3);
            aw_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0: aw_addr = STDOUT_A + 32'($urandom_range(0, 3));
                1: aw_addr = STDERR_A + 32'($urandom_range(0, 3));
                2: aw_addr = EOC_A + 32'($urandom_range(0, 3));
                3: aw_addr = STDOUT_A + 32'd4;
                default: aw_addr = $urandom();
            endcase
            w_valid = ($urandom_range(0, 9) < 4);
            w_ready = ($urandom_range(0, 9) < 7);
            w_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            w_strb  = 4'($urandom_range(0, 15));
            w_last  = ($urandom_range(0, 9) < 6);
            tick();
        end
        idle();
        rst = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
